// File: rtl/led_breath_pkg.sv
// Shared definitions for the LED breathing controller: phase encodings and
// default timing derived from the 48 MHz system clock and its /1024 strobe.
package led_breath_pkg;

  typedef enum logic [1:0] {
    PH_RISE    = 2'd0,
    PH_HOLD_HI = 2'd1,
    PH_FALL    = 2'd2,
    PH_HOLD_LO = 2'd3
  } phase_t;

  localparam int CLK_FREQ     = 48_000_000;
  localparam int STB_PERIOD   = 1024;
  localparam int STB_FREQ     = CLK_FREQ / STB_PERIOD;

  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_MAX      = (1 << DEF_PWM_BITS) - 1;
  // Rounded so one full ramp (MAX steps) lasts about one second.
  localparam int DEF_STEP_DIV = (STB_FREQ + DEF_MAX / 2) / DEF_MAX;
  // Quarter second of strobes, rounded to nearest.
  localparam int DEF_HOLD     = (STB_FREQ + 2) / 4;

  // Width of a counter that must hold 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_breath_pwm_gen.sv
// Free-running PWM: counter plus registered compare against the brightness level.
// Disabling forces the output low on the next edge while the counter keeps running.
module pwm_gen
  import led_breath_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [PWM_BITS-1:0] i_level,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pwm_cnt <= '0;
      o_pwm   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      o_pwm   <= i_en && (pwm_cnt < i_level);
    end
  end

endmodule

// File: rtl/led_breath.sv
// Breathing LED controller: strobe-paced ramp/hold state machine feeding a PWM.
//
//   state      | meaning
//   PH_RISE    | level steps up once every STEP_DIV strobes until MAX
//   PH_HOLD_HI | level parked at MAX for HOLD_HI strobes
//   PH_FALL    | level steps down once every STEP_DIV strobes until 0
//   PH_HOLD_LO | level parked at 0 for HOLD_LO strobes
module led_breath
  import led_breath_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int STEP_DIV = DEF_STEP_DIV,
  parameter int HOLD_HI  = DEF_HOLD,
  parameter int HOLD_LO  = DEF_HOLD
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_stb,
  input  logic                i_en,
  output logic                o_pwm,
  output logic [PWM_BITS-1:0] o_level,
  output logic [1:0]          o_phase
);

  localparam int PRESC_W  = cnt_width(STEP_DIV);
  localparam int HOLD_MAX = (HOLD_HI > HOLD_LO) ? HOLD_HI : HOLD_LO;
  localparam int HOLD_W   = cnt_width(HOLD_MAX);

  localparam logic [PWM_BITS-1:0] LVL_MAX    = '1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0]   HI_LAST    = HOLD_W'(HOLD_HI - 1);
  localparam logic [HOLD_W-1:0]   LO_LAST    = HOLD_W'(HOLD_LO - 1);

  phase_t              state,    state_nxt;
  logic [PWM_BITS-1:0] level,    level_nxt;
  logic [PRESC_W-1:0]  presc,    presc_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                tick;

  // Disabled strobes are dropped entirely, which freezes every counter.
  assign tick = i_en & i_stb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= PH_RISE;
      level    <= '0;
      presc    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      presc    <= presc_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    presc_nxt = presc;
    hold_nxt  = hold_cnt;
    if (tick) begin
      unique case (state)
        PH_RISE: begin
          if (presc == PRESC_LAST) begin
            presc_nxt = '0;
            level_nxt = level + PWM_BITS'(1);
            // Leave the ramp on the same edge MAX is reached.
            if (level == LVL_MAX - PWM_BITS'(1)) begin
              state_nxt = PH_HOLD_HI;
              hold_nxt  = '0;
            end
          end else begin
            presc_nxt = presc + PRESC_W'(1);
          end
        end
        PH_HOLD_HI: begin
          presc_nxt = '0;
          if (hold_cnt == HI_LAST) begin
            state_nxt = PH_FALL;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        PH_FALL: begin
          if (presc == PRESC_LAST) begin
            presc_nxt = '0;
            level_nxt = level - PWM_BITS'(1);
            if (level == PWM_BITS'(1)) begin
              state_nxt = PH_HOLD_LO;
              hold_nxt  = '0;
            end
          end else begin
            presc_nxt = presc + PRESC_W'(1);
          end
        end
        PH_HOLD_LO: begin
          presc_nxt = '0;
          if (hold_cnt == LO_LAST) begin
            state_nxt = PH_RISE;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state_nxt = PH_RISE;
        end
      endcase
    end
  end

  always_comb begin
    o_phase = state;
    o_level = level;
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_level (level),
    .o_pwm   (o_pwm)
  );

endmodule

// File: doc/led_breath.md
Name: led_breath

Overview:
- Consumes the 46.875 kHz single-cycle strobe from the system clock divider and produces a "breathing" LED drive.
- A strobe-paced state machine ramps a brightness level up, holds it, ramps it down and holds it again.
- A system-clock-rate PWM converts the level to a duty cycle for the RGB LED driver input.

Parameters:
- PWM_BITS, 8: width of the brightness level and PWM counter; MAX = 2^PWM_BITS-1.
- STEP_DIV, 184: strobes per one-LSB level step while ramping (about 1.0 s per ramp at 46.875 kHz); must be ≥1.
- HOLD_HI, 11719: strobes spent at MAX (about 0.25 s); must be ≥1.
- HOLD_LO, 11719: strobes spent at 0; must be ≥1.

Ports:
- i_clk, input, 1: system clock (48 MHz).
- i_rst, input, 1: reset, asynchronous, active-high.
- i_stb, input, 1: divided-clock strobe; each high cycle counts as one tick.
- i_en, input, 1: run enable.
- o_pwm, output, 1: registered PWM LED drive.
- o_level, output, PWM_BITS: current brightness level.
- o_phase, output, 2: current state encoding.

Behaviour:
- Clock and reset: one clock (i_clk); reset (i_rst) is asynchronous and active-high.
- Reset values: state=RISE (0), o_level=0, o_phase=0, o_pwm=0; prescaler, hold counter and PWM counter all 0. Asserting reset mid-ramp or mid-hold returns to these values immediately, with no clock required.
- States and encodings: RISE=0, HOLD_HI=1, FALL=2, HOLD_LO=3. o_phase is the state register.
- Prescaler (RISE and FALL only):
  - On i_stb, if presc==STEP_DIV-1 then presc<=0 and a step fires; otherwise presc++.
  - presc is held at 0 in both hold states.
- RISE: on a step, level<=level+1; if level+1==MAX, next state is HOLD_HI with hold_cnt<=0.
- HOLD_HI: on i_stb, if hold_cnt==HOLD_HI-1 then state<=FALL and hold_cnt<=0; otherwise hold_cnt++.
- FALL: on a step, level<=level-1; if level-1==0, next state is HOLD_LO with hold_cnt<=0.
- HOLD_LO: same as HOLD_HI using HOLD_LO; exits to RISE.
- Wrap-around: level never wraps. MAX and 0 are reached exactly, and the state leaves the ramp on the same edge.
- Latency: o_level and o_phase change on the clock edge at which i_stb is sampled high.
- Period: one full cycle = 2·MAX·STEP_DIV + HOLD_HI + HOLD_LO strobes.
- PWM:
  - Free-running PWM_BITS counter, incremented every i_clk and wrapping from MAX to 0.
  - o_pwm <= (pwm_cnt < level), registered, so one cycle of latency.
  - Duty = level/2^PWM_BITS. Level 0 gives constant 0; level MAX gives low for 1 cycle in every 2^PWM_BITS.
- i_en=0:
  - State, level, prescaler and hold counter are frozen, and i_stb is ignored.
  - o_pwm is forced to 0 from the next edge; the PWM counter keeps running.
  - Raising i_en resumes exactly where it stopped.
- i_stb held high for N cycles counts as N ticks; no edge detection is performed.

Decomposition:
- Shared package holds:
  - phase encodings (RISE, HOLD_HI, FALL, HOLD_LO);
  - the 2-bit phase typedef;
  - default timing constants derived from CLK_FREQ=48_000_000 and the 1024-cycle strobe period.
- One natural sub-module: pwm_gen (parameter PWM_BITS; i_clk, i_rst, i_en, i_level → o_pwm), holding the counter and comparator.
- The breathing state machine, prescaler and hold counter stay in led_breath.

Test Plan:
All tests use PWM_BITS=4, STEP_DIV=2, HOLD_HI=3, HOLD_LO=2, with i_stb pulsed one cycle in every 8.

1. Reset: assert i_rst asynchronously between clock edges → o_level=0, o_phase=0 and o_pwm=0 immediately; after release, 2 strobes → o_level=1.
2. Full cycle:
   - 30 strobes → o_level=15, o_phase=1;
   - +3 strobes → o_phase=2;
   - +30 strobes → o_level=0, o_phase=3;
   - +2 strobes → o_phase=0.
   - Total 65 strobes, and the pattern repeats identically.
3. PWM duty: force level 5 by stepping with i_stb → o_pwm high for exactly 5 of every 16 clocks. At level 0 → never high. At level 15 → high for 15 of 16.
4. Enable freeze: drop i_en at o_level=7 in RISE and send 10 strobes → o_level stays 7 and o_pwm=0 from the next edge. Re-enable and send 2 strobes → o_level=8.
5. Back-to-back strobe: hold i_stb high for 4 consecutive cycles from level 0 in RISE → o_level=2.
6. Reset during HOLD_HI (hold_cnt=2) → o_phase=0, o_level=0. Then 2 strobes → o_level=1, with no residual hold count.
